// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared helpers for the segmented pipelined adder
// Stage-count function and configuration legality check used at elaboration.
package pipe_adder_pkg;

   function automatic int calc_nstg(input int width, input int seg);
      return width / seg;
   endfunction

   function automatic bit cfg_ok(input int width, input int seg);
      return (width >= 2) && (seg >= 1) && (seg <= width) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// rtl/pipe_adder_seg.sv - one SEG-bit adder slice with registered sum and carry
// Holds its outputs while en is low.
module pipe_adder_seg #(
   parameter int SEG = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] sum,
   output logic           co
);

   logic [SEG:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
         co  <= 1'b0;
      end else if (en) begin
         {co, sum} <= total;
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/subtract, one SEG-bit segment per stage
// Inputs are skewed per segment, carries ripple stage to stage, sums are deskewed.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out,
   output logic             ovf
);

   localparam int NSTG = calc_nstg(WIDTH, SEG);

   if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be >= 2 and a multiple of SEG");
   end

   logic            en;
   logic [NSTG-1:0] vld;
   logic [NSTG-1:0] cy;
   logic            msb_a_q;
   logic            msb_b_q;

   assign en = ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else if (en) begin
         vld[0] <= in_valid;
         for (int i = 1; i < NSTG; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int DLY = NSTG - 1 - k;

      logic [SEG-1:0] a_sk;
      logic [SEG-1:0] b_sk;
      logic [SEG-1:0] b_eff;
      logic [SEG-1:0] seg_sum;
      logic           sub_sk;
      logic           ci;

      // sub rides the skew line with its segment so each stage inverts its own B bits
      if (k == 0) begin : g_in
         assign a_sk   = a[0 +: SEG];
         assign b_sk   = b[0 +: SEG];
         assign sub_sk = sub;
      end else begin : g_skew
         logic [SEG-1:0] a_sr   [k];
         logic [SEG-1:0] b_sr   [k];
         logic           sub_sr [k];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < k; i++) begin
                  a_sr[i]   <= '0;
                  b_sr[i]   <= '0;
                  sub_sr[i] <= 1'b0;
               end
            end else if (en) begin
               a_sr[0]   <= a[k*SEG +: SEG];
               b_sr[0]   <= b[k*SEG +: SEG];
               sub_sr[0] <= sub;
               for (int i = 1; i < k; i++) begin
                  a_sr[i]   <= a_sr[i-1];
                  b_sr[i]   <= b_sr[i-1];
                  sub_sr[i] <= sub_sr[i-1];
               end
            end
         end

         assign a_sk   = a_sr[k-1];
         assign b_sk   = b_sr[k-1];
         assign sub_sk = sub_sr[k-1];
      end

      assign b_eff = b_sk ^ {SEG{sub_sk}};

      if (k == 0) begin : g_ci0
         assign ci = sub_sk | cin;
      end else begin : g_cin
         assign ci = cy[k-1];
      end

      pipe_adder_seg #(
         .SEG (SEG)
      ) u_seg (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .a   (a_sk),
         .b   (b_eff),
         .ci  (ci),
         .sum (seg_sum),
         .co  (cy[k])
      );

      if (DLY == 0) begin : g_direct
         assign sum_out[k*SEG +: SEG] = seg_sum;
      end else begin : g_deskew
         logic [SEG-1:0] d_sr [DLY];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DLY; i++) begin
                  d_sr[i] <= '0;
               end
            end else if (en) begin
               d_sr[0] <= seg_sum;
               for (int i = 1; i < DLY; i++) begin
                  d_sr[i] <= d_sr[i-1];
               end
            end
         end

         assign sum_out[k*SEG +: SEG] = d_sr[DLY-1];
      end

      // MSB operand bits kept alongside the top slice to recover the carry into the MSB
      if (k == NSTG - 1) begin : g_msb
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               msb_a_q <= 1'b0;
               msb_b_q <= 1'b0;
            end else if (en) begin
               msb_a_q <= a_sk[SEG-1];
               msb_b_q <= b_eff[SEG-1];
            end
         end
      end
   end

   assign out_valid = vld[NSTG-1];
   assign c_out     = cy[NSTG-1];
   assign ovf       = msb_a_q ^ msb_b_q ^ sum_out[WIDTH-1] ^ c_out;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder
// Four configurations against an arithmetic reference model.
module tb_pipe_adder;

   typedef struct packed {
      logic        v;
      logic [31:0] s;
      logic        c;
      logic        o;
   } res_t;

   localparam int N32 = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;

   logic        vin32, cin32, sub32;
   logic [31:0] a32, b32;
   logic        ov32, c32, o32;
   logic [31:0] s32;

   logic        vin8, cin8, sub8;
   logic [7:0]  a8, b8;
   logic        ov8 [3];
   logic [7:0]  s8  [3];
   logic        c8  [3];
   logic        o8  [3];

   int   n_chk  = 0;
   int   n_fail = 0;
   res_t exp_q [$];
   res_t last;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(32), .SEG(8)) u_d32 (
      .clk(clk), .rst(rst), .in_valid(vin32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
      .stall(stall), .out_valid(ov32), .sum_out(s32), .c_out(c32), .ovf(o32));

   pipe_adder #(.WIDTH(8), .SEG(4)) u_d84 (
      .clk(clk), .rst(rst), .in_valid(vin8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .stall(stall), .out_valid(ov8[0]), .sum_out(s8[0]), .c_out(c8[0]), .ovf(o8[0]));

   pipe_adder #(.WIDTH(8), .SEG(1)) u_d81 (
      .clk(clk), .rst(rst), .in_valid(vin8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .stall(stall), .out_valid(ov8[1]), .sum_out(s8[1]), .c_out(c8[1]), .ovf(o8[1]));

   pipe_adder #(.WIDTH(8), .SEG(8)) u_d88 (
      .clk(clk), .rst(rst), .in_valid(vin8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .stall(stall), .out_valid(ov8[2]), .sum_out(s8[2]), .c_out(c8[2]), .ovf(o8[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Signed overflow taken from operand/result signs, not from carries
   function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic ci, input logic sb);
      logic [63:0] mask, be, full, aa;
      res_t r;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'd0, av} & mask;
      be   = sb ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
      full = aa + be + ((sb || ci) ? 64'd1 : 64'd0);
      r.v  = 1'b1;
      r.s  = full[31:0] & mask[31:0];
      r.c  = full[w];
      r.o  = (aa[w-1] == be[w-1]) && (full[w-1] != aa[w-1]);
      return r;
   endfunction

   task automatic tick32();
      res_t e, got;
      logic stalled;
      stalled = stall;
      e   = model(32, a32, b32, cin32, sub32);
      e.v = vin32;
      @(posedge clk);
      #1;
      if (stalled) begin
         chk("hold_valid", 64'(ov32), 64'(last.v));
         chk("hold_sum",   64'(s32),  64'(last.s));
         chk("hold_cout",  64'(c32),  64'(last.c));
         chk("hold_ovf",   64'(o32),  64'(last.o));
      end else begin
         exp_q.push_back(e);
         if (exp_q.size() == N32) begin
            got = exp_q.pop_front();
            chk("valid32", 64'(ov32), 64'(got.v));
            if (got.v) begin
               chk("sum32",  64'(s32), 64'(got.s));
               chk("cout32", 64'(c32), 64'(got.c));
               chk("ovf32",  64'(o32), 64'(got.o));
            end
         end else begin
            chk("valid32_fill", 64'(ov32), 64'd0);
         end
      end
      last.v = ov32;
      last.s = s32;
      last.c = c32;
      last.o = o32;
   endtask

   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb);
      int         lat [3];
      int         nv  [3];
      logic [7:0] gs  [3];
      logic       gc  [3];
      logic       go  [3];
      int         explat [3];
      res_t       e;
      explat[0] = 2;
      explat[1] = 8;
      explat[2] = 1;
      for (int d = 0; d < 3; d++) begin
         lat[d] = 0;
         nv[d]  = 0;
         gs[d]  = '0;
         gc[d]  = 1'b0;
         go[d]  = 1'b0;
      end
      a8 = av; b8 = bv; cin8 = ci; sub8 = sb; vin8 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         vin8 = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (ov8[d]) begin
               nv[d]++;
               if (lat[d] == 0) begin
                  lat[d] = c;
                  gs[d]  = s8[d];
                  gc[d]  = c8[d];
                  go[d]  = o8[d];
               end
            end
         end
      end
      e = model(8, {24'd0, av}, {24'd0, bv}, ci, sb);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("lat8_%0d", d),   64'(lat[d]), 64'(explat[d]));
         chk($sformatf("count8_%0d", d), 64'(nv[d]),  64'd1);
         chk($sformatf("sum8_%0d", d),   64'(gs[d]),  64'(e.s[7:0]));
         chk($sformatf("cout8_%0d", d),  64'(gc[d]),  64'(e.c));
         chk($sformatf("ovf8_%0d", d),   64'(go[d]),  64'(e.o));
      end
   endtask

   initial begin
      int lat;
      int ed;
      int nvalid;

      rst = 1'b1; stall = 1'b0;
      vin32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
      vin8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      last = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid32", 64'(ov32), 64'd0);
      chk("rst_sum32",   64'(s32),  64'd0);
      chk("rst_cout32",  64'(c32),  64'd0);
      chk("rst_ovf32",   64'(o32),  64'd0);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_valid8_%0d", d), 64'(ov8[d]), 64'd0);
         chk($sformatf("rst_sum8_%0d", d),   64'(s8[d]),  64'd0);
         chk($sformatf("rst_cout8_%0d", d),  64'(c8[d]),  64'd0);
         chk($sformatf("rst_ovf8_%0d", d),   64'(o8[d]),  64'd0);
      end
      rst = 1'b0;

      run8(8'hFF, 8'h01, 1'b0, 1'b0);
      run8(8'h80, 8'h01, 1'b0, 1'b1);
      run8(8'h00, 8'h01, 1'b0, 1'b1);
      run8(8'h5A, 8'hA5, 1'b1, 1'b0);
      run8(8'h10, 8'h01, 1'b1, 1'b1);
      run8(8'h7F, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end

      // random stream with bubbles and occasional stalls; inputs held while stalled
      for (int i = 0; i < 1200; i++) begin
         if (!stall) begin
            a32   = $urandom;
            b32   = $urandom;
            cin32 = 1'($urandom);
            sub32 = 1'($urandom);
            vin32 = ($urandom_range(0, 9) != 0);
         end
         stall = ($urandom_range(0, 15) == 0);
         tick32();
      end
      stall = 1'b0;
      vin32 = 1'b0;
      repeat (5) tick32();

      // two beats in flight then a 3-cycle stall
      a32 = 32'h1234_5678; b32 = 32'h0FED_CBA9; cin32 = 1'b1; sub32 = 1'b0; vin32 = 1'b1;
      tick32();
      a32 = 32'h8000_0000; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b1;
      tick32();
      ed = 2; lat = 0; nvalid = 0;
      vin32 = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick32();
         ed++;
         nvalid += int'(ov32);
      end
      stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick32();
         ed++;
         nvalid += int'(ov32);
         if (ov32 && lat == 0) lat = ed;
      end
      chk("stall_latency", 64'(lat), 64'd7);
      chk("stall_count",   64'(nvalid), 64'd2);

      // reset with beats in flight and a result on the outputs
      for (int i = 0; i < 6; i++) begin
         a32 = $urandom | 32'h1; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
         vin32 = 1'b1;
         tick32();
      end
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(ov32), 64'd0);
      chk("midrst_sum",   64'(s32),  64'd0);
      chk("midrst_cout",  64'(c32),  64'd0);
      chk("midrst_ovf",   64'(o32),  64'd0);
      exp_q.delete();
      vin32 = 1'b0;
      @(posedge clk);
      #1;
      chk("inrst_valid", 64'(ov32), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last = '0;
      nvalid = 0;
      for (int i = 0; i < 6; i++) begin
         tick32();
         nvalid += int'(ov32);
      end
      chk("postrst_quiet", 64'(nvalid), 64'd0);
      a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; vin32 = 1'b1;
      tick32();
      vin32 = 1'b0;
      lat = 0;
      for (int i = 2; i <= 8; i++) begin
         tick32();
         if (ov32 && lat == 0) lat = i;
      end
      chk("postrst_latency", 64'(lat), 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
